// File: rtl/apb_soc_timer.sv
// APB timer peripheral: prescaled 32-bit up-counter with compare match, overflow flag,
// one-shot and auto-reload modes, and a level interrupt.
module apb_soc_timer #(
  parameter int unsigned AddrWidth  = 12,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned PrescWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [DataWidth-1:0] pwdata_i,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 irq_o
);

  localparam logic [AddrWidth-1:0] OffCtrl   = AddrWidth'(12'h000);
  localparam logic [AddrWidth-1:0] OffPresc  = AddrWidth'(12'h004);
  localparam logic [AddrWidth-1:0] OffCount  = AddrWidth'(12'h008);
  localparam logic [AddrWidth-1:0] OffCmp    = AddrWidth'(12'h00C);
  localparam logic [AddrWidth-1:0] OffStatus = AddrWidth'(12'h010);

  logic [3:0]            ctrl_q, ctrl_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [PrescWidth-1:0] pcnt_q, pcnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           cmp_q, cmp_d;
  logic                  match_q, match_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;

  logic access, addr_ok, wr_en;
  logic wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic tick, is_match, is_max;
  logic match_set, ovf_set, oneshot_clr;
  logic [DataWidth-1:0] rdata;

  assign access    = psel_i & penable_i;
  assign addr_ok   = (paddr_i[1:0] == 2'b00) && (paddr_i <= OffStatus);
  assign pslverr_o = access & ~addr_ok;
  assign pready_o  = 1'b1;

  // Erroring writes are dropped entirely by gating every register strobe on addr_ok.
  assign wr_en     = access & pwrite_i & addr_ok;
  assign wr_ctrl   = wr_en & (paddr_i == OffCtrl);
  assign wr_presc  = wr_en & (paddr_i == OffPresc);
  assign wr_count  = wr_en & (paddr_i == OffCount);
  assign wr_cmp    = wr_en & (paddr_i == OffCmp);
  assign wr_status = wr_en & (paddr_i == OffStatus);

  assign tick     = ctrl_q[0] & (pcnt_q == presc_q);
  assign is_match = (count_q == cmp_q);
  assign is_max   = &count_q;

  always_comb begin
    pcnt_d = pcnt_q;
    if (wr_presc) begin
      pcnt_d = '0;
    end else if (ctrl_q[0]) begin
      pcnt_d = tick ? '0 : pcnt_q + PrescWidth'(1);
    end
  end

  always_comb begin
    count_d     = count_q;
    match_set   = 1'b0;
    ovf_set     = 1'b0;
    oneshot_clr = 1'b0;
    if (tick) begin
      if (is_match) begin
        match_set   = 1'b1;
        count_d     = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
        // A match at the all-ones value without reload still wraps, so it overflows too.
        ovf_set     = is_max & ~ctrl_q[1];
        oneshot_clr = ctrl_q[3];
      end else if (is_max) begin
        count_d = 32'd0;
        ovf_set = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    if (wr_count) count_d = pwdata_i[31:0];
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (oneshot_clr) ctrl_d[0] = 1'b0;
    if (wr_ctrl)     ctrl_d = pwdata_i[3:0];
    presc_d = wr_presc ? pwdata_i[PrescWidth-1:0] : presc_q;
    cmp_d   = wr_cmp ? pwdata_i[31:0] : cmp_q;
    // Hardware set takes precedence over a same-cycle write-1-to-clear.
    match_d = match_set | (match_q & ~(wr_status & pwdata_i[0]));
    ovf_d   = ovf_set | (ovf_q & ~(wr_status & pwdata_i[1]));
    irq_d   = ctrl_d[2] & match_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    rdata = '0;
    case (paddr_i)
      OffCtrl:   rdata = DataWidth'(ctrl_q);
      OffPresc:  rdata = DataWidth'(presc_q);
      OffCount:  rdata = DataWidth'(count_q);
      OffCmp:    rdata = DataWidth'(cmp_q);
      OffStatus: rdata = DataWidth'({ovf_q, match_q});
      default:   rdata = '0;
    endcase
  end

  assign prdata_o = (access & addr_ok) ? rdata : '0;

endmodule

// File: tb/tb_apb_soc_timer.sv
// Directed bench for apb_soc_timer: each step's expected value is worked out by hand
// from the cycle at which the enabling write commits.
module tb_apb_soc_timer;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int total = 0;
  int bad   = 0;

  apb_soc_timer #(
    .AddrWidth (12),
    .DataWidth (32),
    .PrescWidth(16)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Setup phase spans one edge; the write commits at the following edge.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Sampled data reflects state just after the setup-phase edge.
  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err,
                        output logic rdy);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; err = pslverr; rdy = pready;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        r;

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: reset values
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      apb_rd(12'(i * 4), d, e, r);
      check($sformatf("rst_data_%0d", i * 4), d, 32'd0);
      check($sformatf("rst_err_%0d", i * 4), {31'd0, e}, 32'd0);
      check($sformatf("rst_rdy_%0d", i * 4), {31'd0, r}, 32'd1);
    end

    // 2: prescaled count to a match with interrupt
    apb_wr(12'h004, 32'd3, e);
    apb_wr(12'h00C, 32'd5, e);
    apb_wr(12'h000, 32'h5, e);
    repeat (23) @(posedge clk);
    #1 check("t2_irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 check("t2_irq_at_match", {31'd0, irq}, 32'd1);
    apb_rd(12'h008, d, e, r);
    check("t2_count_after", d, 32'd6);
    apb_wr(12'h010, 32'h1, e);
    check("t2_irq_cleared", {31'd0, irq}, 32'd0);
    apb_rd(12'h010, d, e, r);
    check("t2_status_cleared", d, 32'd0);
    apb_wr(12'h000, 32'h0, e);

    // 3: auto-reload with interrupt disabled
    apb_wr(12'h008, 32'd0, e);
    apb_wr(12'h010, 32'h3, e);
    apb_wr(12'h004, 32'd0, e);
    apb_wr(12'h00C, 32'd2, e);
    apb_wr(12'h000, 32'h3, e);
    apb_rd(12'h008, d, e, r);
    check("t3_count_a", d, 32'd1);
    apb_rd(12'h010, d, e, r);
    check("t3_status", d, 32'h1);
    apb_rd(12'h008, d, e, r);
    check("t3_count_b", d, 32'd2);
    check("t3_irq", {31'd0, irq}, 32'd0);
    apb_rd(12'h008, d, e, r);
    check("t3_count_c", d, 32'd1);
    apb_wr(12'h000, 32'h0, e);

    // 4: one-shot stops the counter after the match
    apb_wr(12'h008, 32'd0, e);
    apb_wr(12'h010, 32'h3, e);
    apb_wr(12'h00C, 32'd1, e);
    apb_wr(12'h000, 32'h9, e);
    apb_rd(12'h008, d, e, r);
    check("t4_count_a", d, 32'd1);
    apb_rd(12'h000, d, e, r);
    check("t4_ctrl", d, 32'h8);
    apb_rd(12'h008, d, e, r);
    check("t4_count_frozen", d, 32'd2);
    apb_rd(12'h010, d, e, r);
    check("t4_status", d, 32'h1);

    // 5a: overflow then match at zero
    apb_wr(12'h010, 32'h3, e);
    apb_wr(12'h00C, 32'd0, e);
    apb_wr(12'h008, 32'hFFFF_FFFE, e);
    apb_wr(12'h000, 32'h1, e);
    @(posedge clk);
    apb_rd(12'h008, d, e, r);
    check("t5_count_wrap", d, 32'd0);
    apb_rd(12'h010, d, e, r);
    check("t5_status", d, 32'h3);
    apb_rd(12'h008, d, e, r);
    check("t5_count_later", d, 32'd4);
    apb_wr(12'h000, 32'h0, e);

    // 5b: W1C of OVF in the same cycle as its hardware set
    apb_wr(12'h010, 32'h3, e);
    apb_wr(12'h008, 32'hFFFF_FFFE, e);
    apb_wr(12'h000, 32'h1, e);
    apb_wr(12'h010, 32'h2, e);
    apb_rd(12'h010, d, e, r);
    check("t5_set_beats_clear", d, 32'h3);
    apb_wr(12'h000, 32'h0, e);

    // 6: error responses
    apb_wr(12'h014, 32'hFFFF_FFFF, e);
    check("t6_wr14_err", {31'd0, e}, 32'd1);
    apb_rd(12'h000, d, e, r);
    check("t6_ctrl_kept", d, 32'h0);
    apb_wr(12'h00E, 32'h1234, e);
    check("t6_wr0e_err", {31'd0, e}, 32'd1);
    apb_rd(12'h00C, d, e, r);
    check("t6_cmp_kept", d, 32'd0);
    apb_rd(12'h006, d, e, r);
    check("t6_rd06_err", {31'd0, e}, 32'd1);
    check("t6_rd06_data", d, 32'd0);

    // 6: reset in the middle of counting
    apb_wr(12'h010, 32'h3, e);
    apb_wr(12'h008, 32'd0, e);
    apb_wr(12'h00C, 32'd3, e);
    apb_wr(12'h000, 32'h5, e);
    repeat (6) @(posedge clk);
    #1 check("t6_irq_pre_rst", {31'd0, irq}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("t6_irq_in_rst", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    apb_rd(12'h008, d, e, r);
    check("t6_count_post_rst", d, 32'd0);
    apb_rd(12'h000, d, e, r);
    check("t6_ctrl_post_rst", d, 32'd0);
    check("t6_irq_post_rst", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
